// File: rtl/display_scan_mux.sv
// display_scan_mux: scan controller for an 8-digit common-anode seven-segment bank.
// Takes a 32-bit hex word over valid/ready and lights one digit at a time with a blanking gap.
//
// Parameters:
//   TICK_DIV     - cycles each digit is lit (>= 2)
//   BLANK_CYCLES - cycles all anodes are dark before each digit (>= 1)
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   din, din_valid    - 32-bit word offer, nibble k drives digit k
//   din_ready         - pending register is free
//   dp_in, digit_en   - live per-digit decimal point / enable (active-high)
//   seg, dp, an       - registered active-low segment, decimal point and anode drives
//   frame_done        - one-cycle pulse during the last SHOW cycle of digit 7
// Optional feature:
//   LEADING_ZERO_BLANK_EN - darken leading-zero digits (digit 0 always shown)
module display_scan_mux #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [31:0] shown;
    logic [31:0] pending;
    logic        pend_full;

    logic        accept;
    logic        blank_end;
    logic        show_end;
    logic        boundary;
    logic        next_show;
    logic        lit;
    logic [3:0]  nib;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h18;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign din_ready  = !pend_full;
    assign accept     = din_valid && din_ready;
    assign blank_end  = (state == BLANK) && (cnt == BLANK_LAST);
    assign show_end   = (state == SHOW) && (cnt == SHOW_LAST);
    assign boundary   = show_end && (idx == 3'd7);
    assign frame_done = boundary;

    // The cycle after this one is a SHOW cycle; idx only moves on SHOW->BLANK,
    // so the current idx is also the digit being driven next cycle.
    assign next_show  = blank_end || ((state == SHOW) && !show_end);

    assign nib = shown[{idx, 2'b00} +: 4];

    always_comb begin
        lit = digit_en[idx];
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != 3'd0) && ((shown >> {idx, 2'b00}) == 32'd0)) begin
            lit = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            cnt       <= '0;
            idx       <= 3'd0;
            shown     <= 32'd0;
            pending   <= 32'd0;
            pend_full <= 1'b0;
            an        <= 8'hFF;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            // accept implies pend_full was clear, so the two never collide
            if (boundary && pend_full) begin
                shown     <= pending;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pending   <= din;
                pend_full <= 1'b1;
            end

            case (state)
                BLANK: begin
                    if (blank_end) begin
                        state <= SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (show_end) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase

            if (next_show) begin
                an  <= lit ? ~(8'd1 << idx) : 8'hFF;
                seg <= decode(nib);
                dp  <= lit ? ~dp_in[idx] : 1'b1;
            end else begin
                an  <= 8'hFF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: self-checking bench for display_scan_mux.
// Position-in-frame reference model, directed scenarios and randomized traffic.
module tb_display_scan_mux;

    localparam int TD   = 4;
    localparam int BC   = 2;
    localparam int DPER = TD + BC;
    localparam int FR   = 8 * DPER;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_done;

    display_scan_mux #(
        .TICK_DIV(TD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dp_in(dp_in),
        .digit_en(digit_en),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: cycle position inside the frame plus word registers
    int          pos = 0;
    logic [31:0] m_shown = '0;
    logic [31:0] m_pend = '0;
    logic        m_full = 1'b0;
    logic        m_acc = 1'b0;
    logic [7:0]  en_q = 8'hFF;
    logic [7:0]  dpi_q = '0;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fd;
    logic        e_rdy;
    logic [6:0]  dec [16];

    function automatic logic [17:0] got();
        return {an, seg, dp, frame_done, din_ready};
    endfunction

    function automatic logic [17:0] want();
        return {e_an, e_seg, e_dp, e_fd, e_rdy};
    endfunction

    function automatic void eval();
        int   slot;
        logic lit;
        slot  = pos / DPER;
        e_fd  = (pos == FR - 1);
        e_rdy = !m_full;
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (pos % DPER >= BC) begin
            lit = en_q[slot];
`ifdef LEADING_ZERO_BLANK_EN
            if (slot > 0 && (m_shown >> (4 * slot)) == 32'd0) lit = 1'b0;
`endif
            if (lit) e_an = ~(8'd1 << slot);
            e_seg = dec[m_shown[4 * slot +: 4]];
            e_dp  = lit ? ~dpi_q[slot] : 1'b1;
        end
    endfunction

    task automatic model_reset();
        m_shown = '0;
        m_pend  = '0;
        m_full  = 1'b0;
        m_acc   = 1'b0;
        pos     = 0;
        en_q    = digit_en;
        dpi_q   = dp_in;
        eval();
    endtask

    // one clock: model follows the word rules at the edge, then sample point
    task automatic step();
        logic bnd;
        logic was_full;
        @(posedge clk);
        bnd      = (pos == FR - 1);
        was_full = m_full;
        m_acc    = din_valid && !was_full;
        if (bnd && was_full) begin
            m_shown = m_pend;
            m_full  = 1'b0;
        end
        if (m_acc) begin
            m_pend = din;
            m_full = 1'b1;
        end
        en_q  = digit_en;
        dpi_q = dp_in;
        pos   = (pos + 1) % FR;
        @(negedge clk);
        eval();
    endtask

    task automatic test_reset();
        int          first_lit;
        logic [7:0]  first_an;
        int          fd_at[$];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (got() !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_values got=%h want=%h", got(), {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
        rst_n = 1'b1;
        model_reset();
        first_lit = 0;
        first_an  = 8'hFF;
        for (int c = 1; c <= 100; c++) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL reset_run pos=%0d got=%h want=%h", pos, got(), want());
            end
            if (first_lit == 0 && an !== 8'hFF) begin
                first_lit = c;
                first_an  = an;
            end
            if (frame_done === 1'b1) fd_at.push_back(c);
            step();
        end
        tests++;
        if (first_lit != 3 || first_an !== 8'hFE) begin
            fails++;
            $display("FAIL first_digit got cycle=%0d an=%h want cycle=3 an=fe", first_lit, first_an);
        end
        tests++;
        if (fd_at.size() != 2 || fd_at[0] != 48 || fd_at[1] != 96) begin
            fails++;
            $display("FAIL frame_period got n=%0d want pulses at 48,96", fd_at.size());
        end
    endtask

    task automatic test_load();
        logic [6:0] tbl [8];
        logic [7:0] exp_an;
        int         n;
        tbl = '{7'h0E, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};
        din = 32'h0123ABCF;
        din_valid = 1'b1;
        n = 0;
        while (!(m_shown == 32'h0123ABCF && !m_full) && n < 3 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL load_wait pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            if (m_acc) din_valid = 1'b0;
            n++;
        end
        din_valid = 1'b0;
        for (int c = 0; c < FR; c++) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL load_frame pos=%0d got=%h want=%h", pos, got(), want());
            end
            if (pos % DPER == BC) begin
                exp_an = ~(8'd1 << (pos / DPER));
`ifdef LEADING_ZERO_BLANK_EN
                if (pos / DPER == 7) exp_an = 8'hFF;
`endif
                tests++;
                if ({an, seg} !== {exp_an, tbl[pos / DPER]}) begin
                    fails++;
                    $display("FAIL load_digit%0d got an=%h seg=%h want an=%h seg=%h",
                             pos / DPER, an, seg, exp_an, tbl[pos / DPER]);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        int   rdy_seen;
        int   acc_pos;
        int   p;
        logic fd_seen;
        din = 32'h11111111;
        din_valid = 1'b1;
        n = 0;
        while (n < 2 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL bp_first pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            n++;
            if (m_acc) break;
        end
        din = 32'h22222222;
        rdy_seen = 0;
        acc_pos  = -1;
        fd_seen  = 1'b0;
        n = 0;
        while (n < 3 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL bp_hold pos=%0d got=%h want=%h", pos, got(), want());
            end
            if (din_ready === 1'b1) rdy_seen++;
            if (frame_done === 1'b1) fd_seen = 1'b1;
            p = pos;
            step();
            n++;
            if (m_acc) begin
                acc_pos = p;
                break;
            end
        end
        din_valid = 1'b0;
        tests++;
        if (rdy_seen != 1 || acc_pos != 0 || !fd_seen) begin
            fails++;
            $display("FAIL bp_ready got ready_cycles=%0d accept_pos=%0d fd=%0d want 1,0,1",
                     rdy_seen, acc_pos, fd_seen);
        end
        n = 0;
        while (!(m_shown == 32'h22222222 && !m_full && pos == BC + 1) && n < 3 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL bp_apply pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            n++;
        end
        tests++;
        if (seg !== 7'h24) begin
            fails++;
            $display("FAIL bp_shown got seg=%h want seg=24", seg);
        end
        // word offered in the boundary cycle must wait one more frame
        n = 0;
        while (pos != FR - 1 && n < 2 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL bp_goto pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            n++;
        end
        din = 32'h33333333;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        tests++;
        if (din_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_boundary_ready got=%b want=0", din_ready);
        end
        while (pos != BC + 1) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL bp_boundary pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
        end
        tests++;
        if (seg !== 7'h24) begin
            fails++;
            $display("FAIL bp_boundary_shown got seg=%h want seg=24", seg);
        end
    endtask

    task automatic test_masking();
        int n;
        digit_en = 8'hAA;
        dp_in    = 8'h01;
        n = 0;
        while (pos != 0 && n < 2 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL mask_goto pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            n++;
        end
        for (int c = 0; c < FR; c++) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL mask_frame pos=%0d got=%h want=%h", pos, got(), want());
            end
            if (pos % DPER == BC + 1) begin
                tests++;
                if ((pos / DPER) % 2 == 0) begin
                    if ({an, dp} !== {8'hFF, 1'b1}) begin
                        fails++;
                        $display("FAIL mask_dark%0d got an=%h dp=%b want an=ff dp=1",
                                 pos / DPER, an, dp);
                    end
                end else if ({an, dp} !== {~(8'd1 << (pos / DPER)), 1'b1}) begin
                    fails++;
                    $display("FAIL mask_lit%0d got an=%h dp=%b want an=%h dp=1",
                             pos / DPER, an, dp, ~(8'd1 << (pos / DPER)));
                end
            end
            step();
        end
        digit_en = 8'hFF;
        dp_in    = 8'h00;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            digit_en = 8'($urandom);
            dp_in    = 8'($urandom);
            for (int c = 0; c < 2 * FR; c++) begin
                tests++;
                if (got() !== want()) begin
                    fails++;
                    $display("FAIL random it=%0d pos=%0d got=%h want=%h", it, pos, got(), want());
                end
                din       = $urandom >> (4 * $urandom_range(0, 7));
                din_valid = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
                if ($urandom_range(0, 15) == 0) dp_in = 8'($urandom);
                step();
            end
        end
        din_valid = 1'b0;
        digit_en  = 8'hFF;
    endtask

    task automatic test_reset_mid();
        int n;
        din = 32'h89ABCDEF;
        din_valid = 1'b1;
        n = 0;
        while (!(pos == 5 * DPER + BC + 1 && m_full) && n < 3 * FR) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL rmid_goto pos=%0d got=%h want=%h", pos, got(), want());
            end
            step();
            n++;
        end
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (got() !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rmid_values got=%h want=%h", got(), {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2 * FR; c++) begin
            tests++;
            if (got() !== want()) begin
                fails++;
                $display("FAIL rmid_run pos=%0d got=%h want=%h", pos, got(), want());
            end
            if (pos % DPER == BC + 1) begin
                tests++;
                if ({seg, din_ready} !== {7'h40, 1'b1}) begin
                    fails++;
                    $display("FAIL rmid_zero got seg=%h rdy=%b want seg=40 rdy=1", seg, din_ready);
                end
            end
            step();
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        logic [31:0] words [2];
        logic [7:0]  exp_an;
        logic [6:0]  exp_seg;
        int          n;
        int          s;
        words = '{32'h000000A5, 32'h00000000};
        digit_en = 8'hFF;
        for (int w = 0; w < 2; w++) begin
            din = words[w];
            din_valid = 1'b1;
            n = 0;
            while (!(m_shown == words[w] && !m_full && pos == 0) && n < 3 * FR) begin
                tests++;
                if (got() !== want()) begin
                    fails++;
                    $display("FAIL lzb_wait pos=%0d got=%h want=%h", pos, got(), want());
                end
                step();
                if (m_acc) din_valid = 1'b0;
                n++;
            end
            din_valid = 1'b0;
            for (int c = 0; c < FR; c++) begin
                tests++;
                if (got() !== want()) begin
                    fails++;
                    $display("FAIL lzb_frame pos=%0d got=%h want=%h", pos, got(), want());
                end
                if (pos % DPER == BC + 1) begin
                    s = pos / DPER;
                    exp_an  = 8'hFF;
                    exp_seg = 7'h40;
                    if (s == 0) begin
                        exp_an  = 8'hFE;
                        exp_seg = (w == 0) ? 7'h12 : 7'h40;
                    end else if (s == 1 && w == 0) begin
                        exp_an  = 8'hFD;
                        exp_seg = 7'h08;
                    end
                    tests++;
                    if (an !== exp_an || (exp_an !== 8'hFF && seg !== exp_seg)) begin
                        fails++;
                        $display("FAIL lzb_digit%0d got an=%h seg=%h want an=%h seg=%h",
                                 s, an, seg, exp_an, exp_seg);
                    end
                end
                step();
            end
        end
    endtask
`endif

    initial begin
        dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_load();
        test_back_to_back();
        test_masking();
        test_random();
        test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment bank. It accepts a 32-bit hex word through a valid/ready handshake and owns the shared segment bus, decoding one nibble per slot. It drives one anode at a time with a blanking gap between digits to suppress ghosting. It sits between system logic that produces display values and the top-level segment/anode pins, replacing static per-digit decoding.

## Interface
- TICK_DIV, 50000, clock cycles each digit is lit (SHOW length); ≥2
- BLANK_CYCLES, 64, clock cycles all anodes are off before each digit (BLANK length); ≥1
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- din  input  32  hex value; nibble k → digit k (digit 0 = din[3:0])
- din_valid  input  1  din offered
- din_ready  output  1  block can take a word into the pending register
- dp_in  input  8  decimal points, active-high, bit k → digit k; sampled live, not buffered
- digit_en  input  8  digit k enabled when 1; sampled live
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- dp  output  1  decimal point, active-low, registered
- an  output  8  anodes, active-low, one-hot-low or all high, registered
- frame_done  output  1  one-cycle pulse at end of digit 7 SHOW

## Operation
- Registers: shown[31:0] (displayed), pending[31:0], pend_full, idx[2:0], cnt, state ∈ {BLANK, SHOW}.
- Accept on din_valid && din_ready: pending ← din, pend_full ← 1. din_ready = !pend_full.
- BLANK: an = 8'hFF, seg = 7'h7F, dp = 1; cnt counts BLANK_CYCLES then → SHOW, cnt ← 0.
- SHOW: an[idx] = 0 if digit enabled, else an = 8'hFF (slot time preserved); seg = decode(shown[4·idx+3:4·idx]); dp = !dp_in[idx]. After TICK_DIV cycles → BLANK, idx ← idx+1 (7 wraps to 0).
- Frame boundary (SHOW end with idx = 7): frame_done = 1; if pend_full (register value at start of that cycle), shown ← pending, pend_full ← 0.
- A word accepted in the boundary cycle itself stays pending until the next boundary.
- Decode (active-low hex, 7-bit): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 B:03 C:46 D:21 E:06 F:0E.
- cnt width = $clog2(max(TICK_DIV, BLANK_CYCLES)).

## Timing
- Reset (async assert, sync-release behaviour): state = BLANK, idx = 0, cnt = 0, shown = 0, pend_full = 0; an = 8'hFF, seg = 7'h7F, dp = 1, din_ready = 1, frame_done = 0.
- Digit period = BLANK_CYCLES + TICK_DIV cycles; frame = 8 × that.
- din_ready falls the cycle after accept; rises the cycle after the applying frame_done.
- Accept → visible: new value appears on seg in the first digit-0 SHOW cycle after the applying boundary (BLANK_CYCLES + 1 cycles after frame_done).
- Outputs change only at state transitions (plus live digit_en/dp_in, registered, 1-cycle lag).
- Reset mid-frame: all outputs return to reset values immediately; pending word discarded.

## Configuration
- LEADING_ZERO_BLANK_EN defined: during SHOW, digit k is forced dark (an = 8'hFF) when k > 0 and shown[31:4k] == 0; digit 0 always lit if enabled. Combined with digit_en by AND.
- Undefined: every enabled digit shows its nibble, including leading zeros.

## Test plan
- Reset: hold rst_n = 0 → an = FF, seg = 7F, dp = 1, din_ready = 1, frame_done = 0; release, TICK_DIV = 4, BLANK_CYCLES = 2 → first an = FE on cycle 3, frame_done every 48 cycles.
- Load: din = 32'h0123ABCF → after next frame_done, digit slots 0..7 show seg 0E,46,03,08,30,24,79,40 with an = FE,FD,…,7F.
- Backpressure: accept 32'h11111111, offer 32'h22222222 → din_ready = 0 until applying frame_done, 2222… accepted after, displayed one frame later.
- Masking: digit_en = 8'hAA, dp_in = 8'h01 → even slots an = FF; digit 0 dp stays 1 (dark), odd slots lit.
- Reset mid-SHOW of digit 5 with word pending → outputs to reset values at once, subsequent frames show 0.
- LEADING_ZERO_BLANK_EN defined, din = 32'h000000A5 → only digits 0 (seg 12) and 1 (seg 08) lit; din = 0 → only digit 0 (seg 40) lit.
